// File: rtl/uart_pkg.sv
// Shared UART types: transmit-controller FSM state encoding and data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered full/empty/level flags.
// The head entry is visible combinationally on rd_data while not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the pre-pop state, so a write into a full FIFO is
  // refused even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_nxt = level - 1'b1;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit-side controller: buffers bus writes and sequences the UART
// transmitter one frame at a time with a programmable inter-frame gap.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | waiting for enable and a queued byte
//   ST_START     | tx_start high, tx_data holds FIFO head, head popped
//   ST_WAIT_DONE | frame in flight, waiting for tx_done
//   ST_GAP       | counting idle clocks before the next frame may start
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   enable,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   ctrl_busy,
  output logic                   tx_start,
  output logic                   tx_enable,
  output logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_done
);

  // The gap counter holds GAP_CYCLES-1 down to 0, so GAP lasts GAP_CYCLES clocks.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_e              state;
  tx_state_e              state_nxt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [GAP_W-1:0]       gap_cnt_nxt;
  logic [UART_DATA_W-1:0] fifo_head;
  logic                   fifo_pop;
  logic                   wr_dropped;

  assign fifo_pop   = (state == ST_START);
  assign wr_dropped = wr_en && full;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Next-state and gap-counter logic; tx_done only matters in WAIT_DONE.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && !empty) state_nxt = ST_START;
      end
      ST_START: begin
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (GAP_CYCLES > 0) begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered outputs derived from the next state, so
  // tx_start/ctrl_busy line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      tx_start  <= 1'b0;
      ctrl_busy <= 1'b0;
      tx_enable <= 1'b0;
      tx_data   <= '0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      tx_start  <= (state_nxt == ST_START);
      ctrl_busy <= (state_nxt != ST_IDLE);
      tx_enable <= enable;
      if (state_nxt == ST_START) begin
        tx_data <= fifo_head;
      end
    end
  end

  // Sticky overflow; a dropped write in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_dropped) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural serialising transmitter
// and a byte scoreboard filled at write time and drained at each tx_start.
module tb_uart_tx_ctrl;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   enable;
  logic                   clr_ovf;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   ctrl_busy;
  logic                   tx_start;
  logic                   tx_enable;
  logic [7:0]             tx_data;
  logic                   tx_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q [$];

  // transmitter model state
  logic [9:0] sh;
  logic [9:0] rx_bits;
  logic [7:0] held;
  logic       serial_line;
  int         bit_idx;
  bit         busy_m;
  bit         prev_start;
  bit         have_done;
  bit         gap_check_en;
  int         done_cyc;
  int         frames_done;
  int         starts;

  uart_tx_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .enable    (enable),
    .clr_ovf   (clr_ovf),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .ctrl_busy (ctrl_busy),
    .tx_start  (tx_start),
    .tx_enable (tx_enable),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serialiser: one clock per bit, start/8 data/stop, done pulse after stop.
  initial begin
    tx_done = 1'b0; busy_m = 0; prev_start = 0; have_done = 0;
    frames_done = 0; starts = 0; bit_idx = 0; serial_line = 1'b1;
    sh = '1; rx_bits = '0; held = '0; done_cyc = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_done = 1'b0; busy_m = 0; prev_start = 0; have_done = 0;
      serial_line = 1'b1; bit_idx = 0;
    end else begin
      tx_done = 1'b0;
      if (tx_start) begin
        starts++;
        check("tx_start_width", {31'b0, prev_start}, 0);
        check("start_while_busy", {31'b0, busy_m}, 0);
        check("sb_queue_nonempty", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) check("sb_tx_data", tx_data, exp_q.pop_front());
        if (gap_check_en && have_done) check("done_to_start", cyc - done_cyc, GAP + 2);
        held = tx_data;
        sh = {1'b1, tx_data, 1'b0};
        busy_m = 1; bit_idx = 0;
      end else if (busy_m) begin
        check("tx_data_stable", tx_data, held);
        serial_line = sh[bit_idx];
        rx_bits[bit_idx] = serial_line;
        bit_idx++;
        if (bit_idx == 10) begin
          check("serial_frame", {22'b0, rx_bits}, {22'b0, 1'b1, held, 1'b0});
          busy_m = 0; tx_done = 1'b1;
          done_cyc = cyc; have_done = 1; frames_done++;
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accepted);
    wr_en = 1'b1; wr_data = d;
    if (accepted) exp_q.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 400 && frames_done < target; i++) step();
    check("frames_timeout", frames_done, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && ctrl_busy; i++) step();
    check("idle_timeout", {31'b0, ctrl_busy}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, {31'b0, empty}, 1);
    check({tag, "_full"}, {31'b0, full}, 0);
    check({tag, "_level"}, {29'b0, level}, 0);
    check({tag, "_ovf"}, {31'b0, overflow}, 0);
    check({tag, "_busy"}, {31'b0, ctrl_busy}, 0);
    check({tag, "_start"}, {31'b0, tx_start}, 0);
    check({tag, "_txen"}, {31'b0, tx_enable}, 0);
    check({tag, "_data"}, {24'b0, tx_data}, 0);
  endtask

  initial begin
    int base;
    int sbase;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; enable = 1'b0; clr_ovf = 1'b0;
    gap_check_en = 0;

    // Reset held with write activity and enable toggling
    for (int i = 0; i < 4; i++) begin
      wr_en = ~wr_en; wr_data = 8'h30 + 8'(i); enable = 1'b1;
      step();
      check_reset_outputs("rst_hold");
    end
    wr_en = 1'b0; enable = 1'b0;
    rst_n = 1'b1;
    step();
    check("rel_empty", {31'b0, empty}, 1);
    check("rel_level", {29'b0, level}, 0);

    // Single byte
    enable = 1'b1;
    step();
    check("txen_follow", {31'b0, tx_enable}, 1);
    write_byte(8'hA5, 1);
    check("single_empty", {31'b0, empty}, 0);
    check("single_level", {29'b0, level}, 1);
    check("single_nostart", {31'b0, tx_start}, 0);
    step();
    check("single_start", {31'b0, tx_start}, 1);
    check("single_data", {24'b0, tx_data}, 8'hA5);
    check("single_busy", {31'b0, ctrl_busy}, 1);
    step();
    check("single_start_low", {31'b0, tx_start}, 0);
    check("single_popped", {29'b0, level}, 0);
    for (int i = 0; i < 40 && !tx_done; i++) step();
    check("single_done_seen", {31'b0, tx_done}, 1);
    step();
    check("gap_busy1", {31'b0, ctrl_busy}, 1);
    step();
    check("gap_busy2", {31'b0, ctrl_busy}, 1);
    step();
    check("gap_idle", {31'b0, ctrl_busy}, 0);

    // Burst fill, overflow, then ordered drain
    enable = 1'b0;
    step();
    write_byte(8'h11, 1);
    write_byte(8'h22, 1);
    write_byte(8'h33, 1);
    write_byte(8'h44, 1);
    check("burst_full", {31'b0, full}, 1);
    check("burst_level", {29'b0, level}, 4);
    check("burst_ovf0", {31'b0, overflow}, 0);
    write_byte(8'h55, 0);
    check("ovf_set", {31'b0, overflow}, 1);
    check("ovf_level", {29'b0, level}, 4);
    check("ovf_full", {31'b0, full}, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clr", {31'b0, overflow}, 0);
    wr_en = 1'b1; wr_data = 8'h66; clr_ovf = 1'b1;
    step();
    wr_en = 1'b0; clr_ovf = 1'b0;
    check("ovf_set_wins", {31'b0, overflow}, 1);
    check("ovf_level2", {29'b0, level}, 4);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clr2", {31'b0, overflow}, 0);
    base = frames_done;
    have_done = 0; gap_check_en = 1;
    enable = 1'b1;
    step();
    check("burst_txen", {31'b0, tx_enable}, 1);
    wait_frames(base + 4);
    wait_idle();
    gap_check_en = 0;
    check("burst_sb_drained", exp_q.size(), 0);
    check("burst_empty", {31'b0, empty}, 1);

    // Enable gating mid-frame
    base = frames_done; sbase = starts;
    write_byte(8'hA1, 1);
    write_byte(8'hB2, 1);
    write_byte(8'hC3, 1);
    enable = 1'b0;
    wait_frames(base + 1);
    for (int i = 0; i < 30; i++) step();
    check("gate_frames", frames_done, base + 1);
    check("gate_starts", starts, sbase + 1);
    check("gate_level", {29'b0, level}, 2);
    check("gate_idle", {31'b0, ctrl_busy}, 0);
    check("gate_txen", {31'b0, tx_enable}, 0);
    check("gate_sb", exp_q.size(), 2);
    enable = 1'b1;
    wait_frames(base + 3);
    wait_idle();
    check("gate_drained", exp_q.size(), 0);
    check("gate_empty", {31'b0, empty}, 1);

    // Reset during WAIT_DONE
    enable = 1'b0;
    step();
    write_byte(8'hD1, 1);
    write_byte(8'hD2, 1);
    write_byte(8'hD3, 1);
    enable = 1'b1;
    step();
    check("mid_start", {31'b0, tx_start}, 1);
    step();
    step();
    check("mid_level", {29'b0, level}, 2);
    check("mid_busy", {31'b0, ctrl_busy}, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    sbase = starts;
    for (int i = 0; i < 20; i++) step();
    check("post_rst_starts", starts, sbase);
    check("post_rst_empty", {31'b0, empty}, 1);
    check("post_rst_level", {29'b0, level}, 0);
    check("post_rst_busy", {31'b0, ctrl_busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
